multicycle_alu: RTL
===================

# multicycle_alu

Parametrised, registered successor to the single-cycle MIPS ALU. It adds signed compare, arithmetic shift, XOR, overflow detection, and iterative unsigned multiply/divide into HI/LO registers behind a Start/Busy/Done handshake. It sits in the execute stage of the multicycle MIPS datapath. The control unit issues one operation at a time and waits for Done before consuming ALUResult.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits; must be even and at least 8.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W ≥ WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- Start  input  1  operation request; sampled only when idle (Busy=0).
- ALUOperation  input  5  opcode, listed under Operation.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt/imm).
- Shamt  input  SHAMT_W  shift amount.
- Busy  output  1  high while a multiply or divide iterates.
- Done  output  1  one-cycle pulse when ALUResult/Hi/Lo are valid.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered; 1 when ALUResult==0.
- Overflow  output  1  registered; signed overflow of ADD/SUB, 0 for all other ops.
- Jr  output  1  registered; 1 when the last operation was JR.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

## Operation
Opcodes and results:
- 00000 AND: A&B.
- 00001 OR: A|B.
- 00010 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
- 00011 ADD: A+B.
- 00100 SLL: B<<Shamt.
- 00101 NOR: ~(A|B).
- 00110 SRL: B>>Shamt (logical).
- 00111 SUB: A−B.
- 01000 JR: A.
- 01001 SLT: signed A<B ? 1 : 0.
- 01010 SLTU: unsigned compare, same encoding as SLT.
- 01011 SRA: B>>>Shamt (arithmetic).
- 01100 XOR: A^B.
- 01101 MULTU: {Hi,Lo} = A×B (2·WIDTH-bit product).
- 01110 DIVU: Lo = A/B, Hi = A%B.
- 01111 MFHI: Hi.
- 10000 MFLO: Lo.
- Any other code: result 0.

Rules:
- ADD/SUB wrap modulo 2^WIDTH. Overflow = (operand signs equal for ADD, or differ for SUB) and result sign ≠ sign of A.
- MULTU and DIVU set ALUResult=Lo on completion.
- Zero and Overflow update on every Done.
- DIVU with B=0: Lo = all ones, Hi = A. Latency is unchanged.
- FSM has two states, IDLE and RUN, plus a counter of ceil(log2(WIDTH+1)) bits.
- IDLE, Start=1, single-cycle opcode: register the result and pulse Done next cycle. Stay in IDLE.
- IDLE, Start=1, MULTU/DIVU: latch operands, clear the counter, go to RUN.
- RUN:
  - MULTU performs one shift-add step per cycle.
  - DIVU performs one restoring shift-subtract step per cycle.
  - After WIDTH steps, write Hi/Lo/ALUResult/Zero, pulse Done, and return to IDLE.
- Start while Busy=1 is ignored; the in-flight operation is not disturbed.
- Operands A and B may change after the Start cycle; the latched copies are used.
- Outputs hold their last values between operations. Done is 0 except for its pulse.

## Timing
- Reset (reset=0 at a rising edge):
  - State IDLE, counter 0.
  - Busy=0, Done=0, ALUResult=0, Zero=1, Overflow=0, Jr=0, Hi=0, Lo=0.
  - Reset during RUN aborts the operation; no Done is produced.
- Single-cycle ops: Start high in cycle 0 gives Done=1 and valid outputs in cycle 1 (latency 1). Back-to-back Starts every cycle are allowed, giving one result per cycle.
- MULTU/DIVU:
  - Start in cycle 0.
  - Busy=1 in cycles 1..WIDTH.
  - In cycle WIDTH+1: Busy=0, Done=1, results valid.
  - Latency is WIDTH+1 cycles.
  - A new Start is accepted in cycle WIDTH+1.
- MFHI/MFLO issued in the Done cycle of a MULTU/DIVU read the new Hi/Lo.
- Jr is registered with the result and is valid in the Done cycle.

## Test plan
- Reset then idle → all outputs at reset values. ADD A=7, B=0xFFFFFFF9 → cycle 1: Done=1, ALUResult=0, Zero=1, Overflow=0.
- ADD A=0x7FFFFFFF, B=1 → ALUResult=0x80000000, Overflow=1. SUB A=0x80000000, B=1 → 0x7FFFFFFF, Overflow=1. SLT A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0. SRA B=0x80000000, Shamt=4 → 0xF8000000.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → Busy cycles 1..32, Done in cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001. MFHI then returns 0xFFFFFFFE.
- DIVU A=100, B=7 → Lo=14, Hi=2 at cycle 33. DIVU A=5, B=0 → Lo=0xFFFFFFFF, Hi=5 at cycle 33.
- Start an OR during Busy of a MULTU → ignored; MULTU still finishes at cycle 33 with the correct result. Reset asserted at cycle 10 of a DIVU → no Done, Hi=Lo=0.
- WIDTH=8, SHAMT_W=3 instance: MULTU 0xFF×0x02 → Hi=0x01, Lo=0xFE, Done at cycle 9. LUI B=0x00AB → 0xB0.

Source files
------------

// File: rtl/multicycle_alu.sv
// Registered MIPS execute-stage ALU with iterative MULTU/DIVU into HI/LO.
// Single-cycle ops complete in one clock; multiply/divide take WIDTH+1.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [4:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               Overflow,
  output logic               Jr,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int H  = WIDTH / 2;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_LUI  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_NOR  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_SUB  = 5'b00111;
  localparam logic [4:0] OP_JR   = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_MULT = 5'b01101;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_MFHI = 5'b01111;
  localparam logic [4:0] OP_MFLO = 5'b10000;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc, mq, opnd;

  logic             issue, multi, last;
  logic [WIDTH-1:0] sum, diff, res;
  logic             ovf;

  assign issue = Start && (state == IDLE);
  assign multi = (ALUOperation == OP_MULT) || (ALUOperation == OP_DIV);
  assign last  = (cnt == CW'(WIDTH - 1));
  assign Busy  = (state == RUN);
  assign sum   = A + B;
  assign diff  = A - B;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (issue && multi) state_nx = RUN;
      RUN:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (ALUOperation)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_LUI:  res = {B[H-1:0], {H{1'b0}}};
      OP_ADD: begin
        res = sum;
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  res = B << Shamt;
      OP_NOR:  res = ~(A | B);
      OP_SRL:  res = B >> Shamt;
      OP_SUB: begin
        res = diff;
        ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_JR:   res = A;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, A < B};
      OP_SRA:  res = $signed(B) >>> Shamt;
      OP_XOR:  res = A ^ B;
      OP_MFHI: res = Hi;
      OP_MFLO: res = Lo;
      default: res = '0;
    endcase
  end

  // One iteration step: acc/mq form {Hi,Lo} for multiply, {rem,quot} for divide.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc, acc_nx, mq_nx;

  assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
  assign div_sh  = {acc, mq[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd};
  assign div_acc = div_sh[WIDTH-1:0] - (div_ge ? opnd : '0);
  assign acc_nx  = is_div ? div_acc : mul_sum[WIDTH:1];
  assign mq_nx   = is_div ? {mq[WIDTH-2:0], div_ge}
                          : {mul_sum[0], mq[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      is_div    <= 1'b0;
      acc       <= '0;
      mq        <= '0;
      opnd      <= '0;
      Done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      Jr        <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done <= 1'b0;
      if (issue && multi) begin
        cnt    <= '0;
        is_div <= (ALUOperation == OP_DIV);
        acc    <= '0;
        mq     <= (ALUOperation == OP_DIV) ? A : B;
        opnd   <= (ALUOperation == OP_DIV) ? B : A;
      end else if (issue) begin
        ALUResult <= res;
        Zero      <= (res == '0);
        Overflow  <= ovf;
        Jr        <= (ALUOperation == OP_JR);
        Done      <= 1'b1;
      end else if (state == RUN) begin
        acc <= acc_nx;
        mq  <= mq_nx;
        cnt <= cnt + CW'(1);
        if (last) begin
          Hi        <= acc_nx;
          Lo        <= mq_nx;
          ALUResult <= mq_nx;
          Zero      <= (mq_nx == '0);
          Overflow  <= 1'b0;
          Jr        <= 1'b0;
          Done      <= 1'b1;
        end
      end
    end
  end

endmodule
